// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter letting NUM_MASTERS pipelined Wishbone masters share one slave.
// Grants whole bus cycles, caps outstanding requests and drops acks left over from aborted cycles.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int SEL_WIDTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_stb,
    output logic [NUM_MASTERS-1:0]            o_m_wb_stall,
    output logic [NUM_MASTERS-1:0]            o_m_wb_ack,
    input  logic [NUM_MASTERS-1:0]            i_m_wb_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_m_wb_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_m_wb_dat,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  i_m_wb_sel,
    output logic [DATA_WIDTH-1:0]             o_m_wb_dat,
    output logic                              o_s_wb_cyc,
    output logic                              o_s_wb_stb,
    input  logic                              i_s_wb_stall,
    input  logic                              i_s_wb_ack,
    output logic                              o_s_wb_we,
    output logic [ADDR_WIDTH-1:0]             o_s_wb_adr,
    output logic [DATA_WIDTH-1:0]             o_s_wb_dat,
    output logic [SEL_WIDTH-1:0]              o_s_wb_sel,
    input  logic [DATA_WIDTH-1:0]             i_s_wb_dat,
    output logic [NUM_MASTERS-1:0]            o_grant,
    output logic                              o_abort
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       count;
    logic                   abort;

    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_adr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_dat;
    logic [NUM_MASTERS-1:0][SEL_WIDTH-1:0]  m_sel;

    logic             granted;
    logic             owner_cyc;
    logic             owner_stb;
    logic             limit;
    logic             ack_ok;
    logic             accept;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] cand;

    assign m_adr = i_m_wb_adr;
    assign m_dat = i_m_wb_dat;
    assign m_sel = i_m_wb_sel;

    // owner doubles as the last-served pointer, so it stays valid after the grant is dropped
    assign granted   = (state == ST_GRANTED);
    assign owner_cyc = i_m_wb_cyc[owner];
    assign owner_stb = i_m_wb_stb[owner];
    assign ack_ok    = i_s_wb_ack & (count != '0);
    assign limit     = (count == CNT_MAX) & ~i_s_wb_ack;
    assign accept    = o_s_wb_stb & ~i_s_wb_stall;

    assign o_s_wb_cyc = granted & owner_cyc;
    assign o_s_wb_stb = o_s_wb_cyc & owner_stb & ~limit;
    assign o_s_wb_we  = i_m_wb_we[owner];
    assign o_s_wb_adr = m_adr[owner];
    assign o_s_wb_dat = m_dat[owner];
    assign o_s_wb_sel = m_sel[owner];
    assign o_m_wb_dat = i_s_wb_dat;
    assign o_grant    = grant;
    assign o_abort    = abort;

    // NOTE: every variable driven in always_comb gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        // Walk offsets downward so the nearest requester after the pointer is written last and wins.
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            cand = PTR_W'((int'(owner) + i) % NUM_MASTERS);
            if (i_m_wb_cyc[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        o_m_wb_stall = '1;
        o_m_wb_ack   = '0;
        if (granted) begin
            o_m_wb_stall[owner] = i_s_wb_stall | limit;
            o_m_wb_ack[owner]   = ack_ok & owner_cyc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= PTR_LAST;
            count <= '0;
            abort <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state <= ST_GRANTED;
                        grant <= NUM_MASTERS'(1) << pick_idx;
                        owner <= pick_idx;
                        count <= '0;
                    end
                end
                ST_GRANTED: begin
                    if (!owner_cyc) begin
                        // Acks still owed after this cycle belong to a dead bus cycle and are discarded.
                        state <= ST_IDLE;
                        grant <= '0;
                        count <= '0;
                        abort <= (count > CNT_ONE) | ((count == CNT_ONE) & ~i_s_wb_ack);
                    end else begin
                        count <= count + CNT_W'(accept) - CNT_W'(ack_ok);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
